// File: rtl/mc_control_fsm.sv
// Multi-cycle processor control FSM: sequences fetch/decode/execute/memory/
// writeback states, drives the datapath controls from the current state
// (FETCH write enables gated by memory ready), flags unsupported opcodes and
// counts retired instructions.
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       op_i6,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             iord_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             branch_o,
    output logic             mem_write_o,
    output logic             reg_write_o,
    output logic             mem_to_reg_o,
    output logic             reg_dst_rtrd_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o2,
    output logic [1:0]       pc_src_o2,
    output logic [1:0]       alu_op_o2,
    output logic             illegal_o,
    output logic [3:0]       state_o4,
    output logic [CNT_W-1:0] retired_cnt_o
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RT   = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [3:0]       state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire_s;
    logic             illegal_s;

    // Next-state, opcode latch and retirement decision.
    always_comb begin
        state_d   = S_FETCH;
        op_d      = op_q;
        retire_s  = 1'b0;
        illegal_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Later states only ever look at the latched copy.
                op_d = op_i6;
                case (op_i6)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RT:        state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (op_q == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (mem_ready_i) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready_i) begin
                    state_d  = S_FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            // Unused encodings 12-15 recover to FETCH.
            default: state_d = S_FETCH;
        endcase
        if (retire_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, latched opcode and retired counter; reset wins over every transition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore datapath controls; only FETCH write enables follow mem_ready_i.
    always_comb begin
        mem_req_o      = 1'b0;
        iord_o         = 1'b0;
        ir_write_o     = 1'b0;
        pc_write_o     = 1'b0;
        branch_o       = 1'b0;
        mem_write_o    = 1'b0;
        reg_write_o    = 1'b0;
        mem_to_reg_o   = 1'b0;
        reg_dst_rtrd_o = 1'b0;
        alu_src_a_o    = 1'b0;
        alu_src_b_o2   = 2'b00;
        pc_src_o2      = 2'b00;
        alu_op_o2      = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req_o    = 1'b1;
                alu_src_b_o2 = 2'b01;
                ir_write_o   = mem_ready_i;
                pc_write_o   = mem_ready_i;
            end
            S_DECODE: alu_src_b_o2 = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a_o  = 1'b1;
                alu_src_b_o2 = 2'b10;
            end
            S_MEMRD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEMWR: begin
                mem_req_o   = 1'b1;
                iord_o      = 1'b1;
                mem_write_o = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o2   = 2'b10;
            end
            S_ALUWB: begin
                reg_write_o    = 1'b1;
                reg_dst_rtrd_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o2   = 2'b01;
                pc_src_o2   = 2'b01;
                branch_o    = 1'b1;
            end
            S_ADDIWB: reg_write_o = 1'b1;
            S_JUMP: begin
                pc_src_o2  = 2'b10;
                pc_write_o = 1'b1;
            end
            default: mem_req_o = 1'b0;
        endcase
    end

    assign illegal_o     = illegal_s;
    assign state_o4      = state_q;
    assign retired_cnt_o = cnt_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Table-driven bench for mc_control_fsm: per-cycle vectors of inputs and
// expected state/controls/counter, queued at drive time and checked on the
// falling edge. A second instance with a 4-bit counter shares the stimulus.
module tb_mc_control_fsm;

    // Control word: mem_req iord ir_write pc_write branch mem_write reg_write
    // mem_to_reg reg_dst alu_src_a alu_src_b[2] pc_src[2] alu_op[2] illegal
    localparam logic [16:0] C_FETCH_W  = 17'b1_0_0_0_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FETCH_R  = 17'b1_0_1_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DECODE   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_DEC_ILL  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] C_MEMADR   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MEMRD    = 17'b1_1_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MEMWB    = 17'b0_0_0_0_0_0_1_1_0_0_00_00_00_0;
    localparam logic [16:0] C_MEMWR    = 17'b1_1_0_0_0_1_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_EXEC     = 17'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
    localparam logic [16:0] C_ALUWB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_BRANCH   = 17'b0_0_0_0_1_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_ADDIEX   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_ADDIWB   = 17'b0_0_0_0_0_0_1_0_0_0_00_00_00_0;
    localparam logic [16:0] C_JUMP     = 17'b0_0_0_1_0_0_0_0_0_0_00_10_00_0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  exp_state;
        logic [16:0] exp_ctrl;
        logic [31:0] exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] op;
    logic rdy;

    logic mem_req, iord, ir_write, pc_write, branch, mem_write, reg_write;
    logic mem_to_reg, reg_dst, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic [3:0] state;
    logic [31:0] cnt;

    logic mem_req4, iord4, ir_write4, pc_write4, branch4, mem_write4, reg_write4;
    logic mem_to_reg4, reg_dst4, alu_src_a4, illegal4;
    logic [1:0] alu_src_b4, pc_src4, alu_op4;
    logic [3:0] state4;
    logic [3:0] cnt4;

    logic [16:0] act_ctrl;

    vec_t tbl[$];
    vec_t sb_q[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk_i(clk), .rst_i(rst), .op_i6(op), .mem_ready_i(rdy),
        .mem_req_o(mem_req), .iord_o(iord), .ir_write_o(ir_write),
        .pc_write_o(pc_write), .branch_o(branch), .mem_write_o(mem_write),
        .reg_write_o(reg_write), .mem_to_reg_o(mem_to_reg),
        .reg_dst_rtrd_o(reg_dst), .alu_src_a_o(alu_src_a),
        .alu_src_b_o2(alu_src_b), .pc_src_o2(pc_src), .alu_op_o2(alu_op),
        .illegal_o(illegal), .state_o4(state), .retired_cnt_o(cnt)
    );

    mc_control_fsm #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .op_i6(op), .mem_ready_i(rdy),
        .mem_req_o(mem_req4), .iord_o(iord4), .ir_write_o(ir_write4),
        .pc_write_o(pc_write4), .branch_o(branch4), .mem_write_o(mem_write4),
        .reg_write_o(reg_write4), .mem_to_reg_o(mem_to_reg4),
        .reg_dst_rtrd_o(reg_dst4), .alu_src_a_o(alu_src_a4),
        .alu_src_b_o2(alu_src_b4), .pc_src_o2(pc_src4), .alu_op_o2(alu_op4),
        .illegal_o(illegal4), .state_o4(state4), .retired_cnt_o(cnt4)
    );

    assign act_ctrl = {mem_req, iord, ir_write, pc_write, branch, mem_write,
                       reg_write, mem_to_reg, reg_dst, alu_src_a, alu_src_b,
                       pc_src, alu_op, illegal};

    task automatic add(input logic r, input logic [5:0] o, input logic d,
                       input logic [3:0] s, input logic [16:0] c,
                       input logic [31:0] n);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = d;
        v.exp_state = s; v.exp_ctrl = c; v.exp_cnt = n;
        tbl.push_back(v);
    endtask

    // Scoreboard checker: compare queued expectations mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            vec_t e;
            e = sb_q.pop_front();
            n_vec = n_vec + 1;
            if (state !== e.exp_state) begin
                n_err = n_err + 1;
                $display("FAIL vec%0d state: got %0d expected %0d", n_vec, state, e.exp_state);
            end
            if (act_ctrl !== e.exp_ctrl) begin
                n_err = n_err + 1;
                $display("FAIL vec%0d ctrl: got %b expected %b", n_vec, act_ctrl, e.exp_ctrl);
            end
            if (cnt !== e.exp_cnt) begin
                n_err = n_err + 1;
                $display("FAIL vec%0d retired_cnt: got %0d expected %0d", n_vec, cnt, e.exp_cnt);
            end
            if (cnt4 !== e.exp_cnt[3:0]) begin
                n_err = n_err + 1;
                $display("FAIL vec%0d retired_cnt_w4: got %0d expected %0d", n_vec, cnt4, e.exp_cnt[3:0]);
            end
        end
    end

    initial begin
        // lw, ready always high: 0,1,2,3,4 then FETCH with count 1
        add(1'b0, 6'b000000, 1'b0, 4'd0,  C_FETCH_W, 32'd0);
        add(1'b0, 6'b100011, 1'b1, 4'd0,  C_FETCH_R, 32'd0);
        add(1'b0, 6'b100011, 1'b1, 4'd1,  C_DECODE,  32'd0);
        add(1'b0, 6'b101011, 1'b1, 4'd2,  C_MEMADR,  32'd0);
        add(1'b0, 6'b101011, 1'b1, 4'd3,  C_MEMRD,   32'd0);
        add(1'b0, 6'b000000, 1'b1, 4'd4,  C_MEMWB,   32'd0);
        // sw with three wait cycles in MEMWR
        add(1'b0, 6'b000000, 1'b1, 4'd0,  C_FETCH_R, 32'd1);
        add(1'b0, 6'b101011, 1'b1, 4'd1,  C_DECODE,  32'd1);
        add(1'b0, 6'b100011, 1'b1, 4'd2,  C_MEMADR,  32'd1);
        add(1'b0, 6'b000000, 1'b0, 4'd5,  C_MEMWR,   32'd1);
        add(1'b0, 6'b000000, 1'b0, 4'd5,  C_MEMWR,   32'd1);
        add(1'b0, 6'b000000, 1'b0, 4'd5,  C_MEMWR,   32'd1);
        add(1'b0, 6'b000000, 1'b1, 4'd5,  C_MEMWR,   32'd1);
        // add, addi, beq, j; ready low where it must be ignored
        add(1'b0, 6'b000000, 1'b1, 4'd0,  C_FETCH_R, 32'd2);
        add(1'b0, 6'b000000, 1'b1, 4'd1,  C_DECODE,  32'd2);
        add(1'b0, 6'b111111, 1'b0, 4'd6,  C_EXEC,    32'd2);
        add(1'b0, 6'b111111, 1'b0, 4'd7,  C_ALUWB,   32'd2);
        add(1'b0, 6'b000000, 1'b1, 4'd0,  C_FETCH_R, 32'd3);
        add(1'b0, 6'b001000, 1'b1, 4'd1,  C_DECODE,  32'd3);
        add(1'b0, 6'b000000, 1'b0, 4'd9,  C_ADDIEX,  32'd3);
        add(1'b0, 6'b000000, 1'b0, 4'd10, C_ADDIWB,  32'd3);
        add(1'b0, 6'b000000, 1'b1, 4'd0,  C_FETCH_R, 32'd4);
        add(1'b0, 6'b000100, 1'b1, 4'd1,  C_DECODE,  32'd4);
        add(1'b0, 6'b000000, 1'b0, 4'd8,  C_BRANCH,  32'd4);
        add(1'b0, 6'b000000, 1'b1, 4'd0,  C_FETCH_R, 32'd5);
        add(1'b0, 6'b000010, 1'b1, 4'd1,  C_DECODE,  32'd5);
        add(1'b0, 6'b000000, 1'b0, 4'd11, C_JUMP,    32'd5);
        // illegal opcode: one-cycle flag, back to FETCH, no retirement
        add(1'b0, 6'b000000, 1'b1, 4'd0,  C_FETCH_R, 32'd6);
        add(1'b0, 6'b111111, 1'b1, 4'd1,  C_DEC_ILL, 32'd6);
        add(1'b0, 6'b000000, 1'b0, 4'd0,  C_FETCH_W, 32'd6);
        // reset while stalled in MEMRD
        add(1'b0, 6'b000000, 1'b1, 4'd0,  C_FETCH_R, 32'd6);
        add(1'b0, 6'b100011, 1'b1, 4'd1,  C_DECODE,  32'd6);
        add(1'b0, 6'b000000, 1'b0, 4'd2,  C_MEMADR,  32'd6);
        add(1'b0, 6'b000000, 1'b0, 4'd3,  C_MEMRD,   32'd6);
        add(1'b1, 6'b000000, 1'b0, 4'd3,  C_MEMRD,   32'd6);
        add(1'b0, 6'b000000, 1'b0, 4'd0,  C_FETCH_W, 32'd0);
        // 16 jumps: 32-bit counter reaches 16, 4-bit counter wraps to 0
        for (int k = 0; k < 16; k++) begin
            add(1'b0, 6'b000000, 1'b1, 4'd0,  C_FETCH_R, 32'(k));
            add(1'b0, 6'b000010, 1'b0, 4'd1,  C_DECODE,  32'(k));
            add(1'b0, 6'b000000, 1'b0, 4'd11, C_JUMP,    32'(k));
        end
        add(1'b0, 6'b000000, 1'b0, 4'd0,  C_FETCH_W, 32'd16);

        rst = 1'b1;
        op  = 6'd0;
        rdy = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            #1;
            rst = tbl[i].rst;
            op  = tbl[i].op;
            rdy = tbl[i].rdy;
            sb_q.push_back(tbl[i]);
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port op_i6  input  6  opcode of the instruction register, sampled in DECODE.
REQ-005 SHALL have port mem_ready_i  input  1  memory completes the pending access this cycle.
REQ-006 SHALL have ports mem_req_o, iord_o, ir_write_o, pc_write_o, branch_o, mem_write_o, reg_write_o, mem_to_reg_o, reg_dst_rtrd_o, alu_src_a_o  output  1 each  datapath controls.
REQ-007 SHALL have ports alu_src_b_o2, pc_src_o2, alu_op_o2  output  2 each  datapath mux and ALU controls.
REQ-008 SHALL have port illegal_o  output  1  one-cycle pulse on an unsupported opcode.
REQ-009 SHALL have port state_o4  output  4  current state encoding.
REQ-010 SHALL have port retired_cnt_o  output  CNT_W  count of completed instructions.

Function
REQ-011 SHALL encode states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 -> FETCH next cycle.
REQ-012 SHALL drive every control output as a function of state and mem_ready_i only (Moore, plus ready gating); unlisted outputs are 0 in each state.
REQ-013 FETCH: mem_req_o=1, alu_src_b_o2=01, alu_op_o2=00, pc_src_o2=00; ir_write_o=pc_write_o=mem_ready_i; stay in FETCH while mem_ready_i=0, else -> DECODE.
REQ-014 DECODE: alu_src_b_o2=11, alu_op_o2=00; next by op_i6: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, any other -> FETCH with illegal_o=1 for that cycle.
REQ-015 MEMADR: alu_src_a_o=1, alu_src_b_o2=10; -> MEMRD if the opcode latched in DECODE is 100011, else -> MEMWR.
REQ-016 SHALL latch op_i6 into an internal register on the DECODE cycle; later state decisions use the latched value only.
REQ-017 MEMRD: mem_req_o=1, iord_o=1; hold until mem_ready_i=1, then -> MEMWB.
REQ-018 MEMWB: reg_write_o=1, mem_to_reg_o=1, reg_dst_rtrd_o=0; -> FETCH.
REQ-019 MEMWR: mem_req_o=1, iord_o=1, mem_write_o=1; hold until mem_ready_i=1, then -> FETCH.
REQ-020 EXEC: alu_src_a_o=1, alu_src_b_o2=00, alu_op_o2=10; -> ALUWB. ALUWB: reg_write_o=1, reg_dst_rtrd_o=1; -> FETCH.
REQ-021 BRANCH: alu_src_a_o=1, alu_op_o2=01, pc_src_o2=01, branch_o=1; -> FETCH.
REQ-022 ADDIEX: alu_src_a_o=1, alu_src_b_o2=10, alu_op_o2=00; -> ADDIWB. ADDIWB: reg_write_o=1, reg_dst_rtrd_o=0; -> FETCH.
REQ-023 JUMP: pc_src_o2=10, pc_write_o=1; -> FETCH.
REQ-024 retired_cnt_o SHALL increment by 1 in the cycle after leaving MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, or MEMWR with mem_ready_i=1; it wraps modulo 2^CNT_W; illegal opcodes are not counted.
REQ-025 mem_ready_i SHALL be ignored in states without mem_req_o=1.
REQ-026 Latency per instruction with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-027 rst_i=1 at a clock edge SHALL force state FETCH, latched opcode 0 and retired_cnt_o 0, with priority over all transitions, including mid-access in MEMRD/MEMWR.
REQ-028 In the first cycle after reset, outputs SHALL equal the FETCH values of REQ-013; illegal_o=0.

Verification
REQ-029 Reset, then op_i6=100011, mem_ready_i=1 always -> states 0,1,2,3,4,0; reg_write_o=1 only in state 4; retired_cnt_o=1 after.
REQ-030 op_i6=101011, mem_ready_i low 3 cycles in MEMWR -> state stays 5 for 4 cycles, mem_write_o=1 throughout; count +1 only once.
REQ-031 Sequence add, addi, beq, j, ready=1 -> 4+4+3+3=14 cycles, retired_cnt_o=4, pc_src_o2=01 in BRANCH and 10 in JUMP.
REQ-032 op_i6=111111 in DECODE -> illegal_o=1 exactly one cycle, next state 0, retired_cnt_o unchanged.
REQ-033 rst_i=1 while in MEMRD with mem_ready_i=0 -> next cycle state_o4=0, retired_cnt_o=0, iord_o=0.
REQ-034 CNT_W=4, 16 consecutive j instructions -> retired_cnt_o wraps to 0.
